// File: rtl/frm_pkg.sv
// Shared types and widths for the fault recovery manager.
package frm_pkg;

  // FSM state encoding; values are visible on fsm_state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FREEZE  = 3'd1,
    ST_RECOVER = 3'd2,
    ST_RESUME  = 3'd3,
    ST_HALT    = 3'd4
  } frm_state_e;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned SRC_IDX_W = 4;
  localparam int unsigned RETRY_W   = 4;

  // Width needed to hold a down-counter load value of max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frm_priority_enc.sv
// Lowest-index priority encoder over the fault source lines.
module frm_priority_enc
  import frm_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = SRC_IDX_W
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set index wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = IDX_W'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fault_recovery_manager.sv
// Fault recovery manager: write gating, bounded retry loop, HALT escalation.
// Optional first-fault log built when FRM_FAULT_LOG_EN is defined.
module fault_recovery_manager
  import frm_pkg::*;
#(
  parameter int unsigned          NUM_SRC       = 4,
  parameter logic [NUM_SRC-1:0]   CRIT_MASK     = 4'b1000,
  parameter int unsigned          XLEN          = 32,
  parameter int unsigned          MAX_RETRY     = 3,
  parameter int unsigned          FREEZE_CYCLES = 2,
  parameter int unsigned          CLEAN_WINDOW  = 8,
  parameter int unsigned          COUNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fault_en,
  input  logic [NUM_SRC-1:0]   fault_vec,
  input  logic                 clear_halt,
  input  logic                 pc_write_normal,
  input  logic                 reg_write_normal,
  input  logic                 mem_write_normal,
  input  logic [XLEN-1:0]      pc_current,
  input  logic [XLEN-1:0]      pc_saved,
  output logic                 pc_write_out,
  output logic                 reg_write_out,
  output logic                 mem_write_out,
  output logic [XLEN-1:0]      pc_next,
  output logic                 pc_sel,
  output logic                 insert_nop,
  output logic                 retry_en,
  output logic                 halted,
  output logic [RETRY_W-1:0]   retry_cnt,
  output logic [COUNT_W-1:0]   fault_count,
  output logic [STATE_W-1:0]   fsm_state,
  output logic                 log_valid,
  output logic [SRC_IDX_W-1:0] log_src,
  output logic [XLEN-1:0]      log_pc
);

  localparam int unsigned FRZ_W = cnt_w(FREEZE_CYCLES - 1);
  localparam int unsigned WIN_W = cnt_w(CLEAN_WINDOW - 1);
  localparam logic [FRZ_W-1:0]   FRZ_LOAD  = FRZ_W'(FREEZE_CYCLES - 1);
  localparam logic [WIN_W-1:0]   WIN_LOAD  = WIN_W'(CLEAN_WINDOW - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  frm_state_e           state_q, state_d;
  logic [FRZ_W-1:0]     frz_q, frz_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [COUNT_W-1:0]   fcount_q;

  logic [NUM_SRC-1:0]   fault_gated;
  logic [SRC_IDX_W-1:0] src_idx;
  logic                 f;
  logic                 crit;
  logic                 safe;
  logic                 accept;
  logic                 log_clear;

  assign fault_gated = fault_vec & {NUM_SRC{fault_en}};
  assign crit        = |(fault_gated & CRIT_MASK);

  frm_priority_enc #(
    .N     (NUM_SRC),
    .IDX_W (SRC_IDX_W)
  ) u_prio (
    .req   (fault_gated),
    .idx   (src_idx),
    .valid (f)
  );

  // State, counters and retry count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      frz_q    <= '0;
      win_q    <= '0;
      retry_q  <= '0;
      fcount_q <= '0;
    end else begin
      state_q <= state_d;
      frz_q   <= frz_d;
      win_q   <= win_d;
      retry_q <= retry_d;
      if (accept && (fcount_q != '1)) begin
        fcount_q <= fcount_q + 1'b1;
      end
    end
  end

  // Next-state, counter updates and all state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    frz_d         = frz_q;
    win_d         = win_q;
    retry_d       = retry_q;
    accept        = 1'b0;
    log_clear     = 1'b0;
    pc_next       = pc_current;
    pc_sel        = 1'b0;
    insert_nop    = 1'b0;
    retry_en      = 1'b0;
    halted        = 1'b0;
    safe          = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RESUME: begin
        safe = f;
        if (f) begin
          accept = 1'b1;
          if (crit || (retry_q == RETRY_MAX)) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FREEZE;
            frz_d   = FRZ_LOAD;
          end
        end else if (state_q == ST_RESUME) begin
          if (win_q == '0) begin
            state_d = ST_IDLE;
            retry_d = '0;
          end else begin
            win_d = win_q - 1'b1;
          end
        end
      end
      ST_FREEZE: begin
        safe = 1'b1;
        if (crit) begin
          accept  = 1'b1;
          state_d = ST_HALT;
        end else if (frz_q == '0) begin
          state_d = ST_RECOVER;
        end else begin
          frz_d = frz_q - 1'b1;
        end
      end
      ST_RECOVER: begin
        safe       = 1'b1;
        pc_next    = pc_saved;
        pc_sel     = 1'b1;
        insert_nop = 1'b1;
        retry_en   = 1'b1;
        // A critical fault preempts the retry, so the retry is not counted.
        if (crit) begin
          accept  = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_RESUME;
          win_d   = WIN_LOAD;
          retry_d = retry_q + 1'b1;
        end
      end
      ST_HALT: begin
        safe   = 1'b1;
        halted = 1'b1;
        if (clear_halt) begin
          state_d   = ST_IDLE;
          retry_d   = '0;
          log_clear = 1'b1;
        end
      end
      default: begin
        safe    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pc_write_out  = pc_write_normal  & ~safe;
  assign reg_write_out = reg_write_normal & ~safe;
  assign mem_write_out = mem_write_normal & ~safe;
  assign retry_cnt     = retry_q;
  assign fault_count   = fcount_q;
  assign fsm_state     = state_q;

`ifdef FRM_FAULT_LOG_EN
  logic                 log_valid_q;
  logic [SRC_IDX_W-1:0] log_src_q;
  logic [XLEN-1:0]      log_pc_q;

  // Sticky first-fault capture, released by clear_halt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      log_valid_q <= 1'b0;
      log_src_q   <= '0;
      log_pc_q    <= '0;
    end else if (log_clear) begin
      log_valid_q <= 1'b0;
      log_src_q   <= '0;
      log_pc_q    <= '0;
    end else if (accept && !log_valid_q) begin
      log_valid_q <= 1'b1;
      log_src_q   <= src_idx;
      log_pc_q    <= pc_current;
    end
  end

  assign log_valid = log_valid_q;
  assign log_src   = log_src_q;
  assign log_pc    = log_pc_q;
`else
  logic unused_log;
  assign unused_log = ^{src_idx, log_clear};
  assign log_valid  = 1'b0;
  assign log_src    = '0;
  assign log_pc     = '0;
`endif

endmodule

// File: tb/tb_fault_recovery_manager.sv
// Scoreboard bench for fault_recovery_manager (default parameters).
module tb_fault_recovery_manager;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FREEZE  = 3'd1;
  localparam logic [2:0] S_RECOVER = 3'd2;
  localparam logic [2:0] S_RESUME  = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;
`ifdef FRM_FAULT_LOG_EN
  localparam bit LOG_ON = 1'b1;
`else
  localparam bit LOG_ON = 1'b0;
`endif

  logic        clk, reset_n, fault_en, clear_halt;
  logic [3:0]  fault_vec;
  logic        pc_write_normal, reg_write_normal, mem_write_normal;
  logic [31:0] pc_current, pc_saved;
  logic        pc_write_out, reg_write_out, mem_write_out;
  logic [31:0] pc_next;
  logic        pc_sel, insert_nop, retry_en, halted;
  logic [3:0]  retry_cnt;
  logic [7:0]  fault_count;
  logic [2:0]  fsm_state;
  logic        log_valid;
  logic [3:0]  log_src;
  logic [31:0] log_pc;

  fault_recovery_manager #(
    .NUM_SRC(4), .CRIT_MASK(4'b1000), .XLEN(32), .MAX_RETRY(3),
    .FREEZE_CYCLES(2), .CLEAN_WINDOW(8), .COUNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fault_en(fault_en), .fault_vec(fault_vec),
    .clear_halt(clear_halt), .pc_write_normal(pc_write_normal),
    .reg_write_normal(reg_write_normal), .mem_write_normal(mem_write_normal),
    .pc_current(pc_current), .pc_saved(pc_saved), .pc_write_out(pc_write_out),
    .reg_write_out(reg_write_out), .mem_write_out(mem_write_out), .pc_next(pc_next),
    .pc_sel(pc_sel), .insert_nop(insert_nop), .retry_en(retry_en), .halted(halted),
    .retry_cnt(retry_cnt), .fault_count(fault_count), .fsm_state(fsm_state),
    .log_valid(log_valid), .log_src(log_src), .log_pc(log_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [2:0]  wr;
    logic [31:0] pcn;
    logic [3:0]  rc;
    logic [7:0]  fc;
    logic        lv;
    logic [3:0]  ls;
    logic [31:0] lp;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  m_fcnt;
  logic        m_lv;
  logic [3:0]  m_ls;
  logic [31:0] m_lp;

  // Pop one expectation per cycle and compare mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      checks += 12;
      if (fsm_state !== me.st) begin
        errors++; $display("FAIL %s state: got %0d want %0d", me.tag, fsm_state, me.st);
      end
      if ({pc_write_out, reg_write_out, mem_write_out} !== me.wr) begin
        errors++; $display("FAIL %s writes: got %b want %b", me.tag,
                           {pc_write_out, reg_write_out, mem_write_out}, me.wr);
      end
      if (pc_sel !== (me.st == S_RECOVER)) begin
        errors++; $display("FAIL %s pc_sel: got %b want %b", me.tag, pc_sel, me.st == S_RECOVER);
      end
      if (insert_nop !== (me.st == S_RECOVER)) begin
        errors++; $display("FAIL %s insert_nop: got %b want %b", me.tag, insert_nop, me.st == S_RECOVER);
      end
      if (retry_en !== (me.st == S_RECOVER)) begin
        errors++; $display("FAIL %s retry_en: got %b want %b", me.tag, retry_en, me.st == S_RECOVER);
      end
      if (pc_next !== me.pcn) begin
        errors++; $display("FAIL %s pc_next: got %h want %h", me.tag, pc_next, me.pcn);
      end
      if (halted !== (me.st == S_HALT)) begin
        errors++; $display("FAIL %s halted: got %b want %b", me.tag, halted, me.st == S_HALT);
      end
      if (retry_cnt !== me.rc) begin
        errors++; $display("FAIL %s retry_cnt: got %0d want %0d", me.tag, retry_cnt, me.rc);
      end
      if (fault_count !== me.fc) begin
        errors++; $display("FAIL %s fault_count: got %0d want %0d", me.tag, fault_count, me.fc);
      end
      if (log_valid !== me.lv) begin
        errors++; $display("FAIL %s log_valid: got %b want %b", me.tag, log_valid, me.lv);
      end
      if (log_src !== me.ls) begin
        errors++; $display("FAIL %s log_src: got %0d want %0d", me.tag, log_src, me.ls);
      end
      if (log_pc !== me.lp) begin
        errors++; $display("FAIL %s log_pc: got %h want %h", me.tag, log_pc, me.lp);
      end
    end
  end

  // Randomise the ungated enables, push the expectation for this cycle, advance.
  task automatic cyc(input string tag, input logic [2:0] st, input logic gated,
                     input logic [3:0] rc);
    exp_t e;
    logic [2:0] wn;
    wn = 3'($urandom_range(1, 7));
    {pc_write_normal, reg_write_normal, mem_write_normal} = wn;
    e.tag = tag;
    e.st  = st;
    e.wr  = gated ? 3'b000 : wn;
    e.pcn = (st == S_RECOVER) ? pc_saved : pc_current;
    e.rc  = rc;
    e.fc  = m_fcnt;
    e.lv  = LOG_ON ? m_lv : 1'b0;
    e.ls  = LOG_ON ? m_ls : 4'd0;
    e.lp  = LOG_ON ? m_lp : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_log(input logic [3:0] s, input logic [31:0] p);
    if (!m_lv) begin
      m_lv = 1'b1; m_ls = s; m_lp = p;
    end
  endtask

  task automatic clr_log();
    m_lv = 1'b0; m_ls = '0; m_lp = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fault_en = 1'b1; fault_vec = '0; clear_halt = 1'b0;
    {pc_write_normal, reg_write_normal, mem_write_normal} = 3'b111;
    pc_current = 32'h40; pc_saved = 32'h100;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    m_fcnt = '0;
    clr_log();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    fault_en = 1'b1; fault_vec = 4'b1111; clear_halt = 1'b0;
    {pc_write_normal, reg_write_normal, mem_write_normal} = 3'b101;
    pc_current = 32'h1234; pc_saved = 32'h100;
    repeat (3) begin @(posedge clk); #1; end
    fault_vec = '0;
    #1;
    checks += 6;
    if (fsm_state !== S_IDLE) begin errors++; $display("FAIL rst state: got %0d want 0", fsm_state); end
    if (retry_cnt !== 4'd0) begin errors++; $display("FAIL rst retry_cnt: got %0d want 0", retry_cnt); end
    if (fault_count !== 8'd0) begin errors++; $display("FAIL rst fault_count: got %0d want 0", fault_count); end
    if ({halted, pc_sel, insert_nop, retry_en} !== 4'b0) begin
      errors++; $display("FAIL rst strobes: got %b want 0000", {halted, pc_sel, insert_nop, retry_en});
    end
    if ({pc_write_out, reg_write_out, mem_write_out} !== 3'b101) begin
      errors++; $display("FAIL rst writes: got %b want 101", {pc_write_out, reg_write_out, mem_write_out});
    end
    if ({log_valid, log_src, log_pc} !== 37'd0) begin
      errors++; $display("FAIL rst log: got %b/%0d/%h want 0", log_valid, log_src, log_pc);
    end
    do_reset();
  endtask

  task automatic test_minor_retry();
    do_reset();
    fault_vec = 4'b0001;
    cyc("minor_c0", S_IDLE, 1'b1, 4'd0);
    m_fcnt = 8'd1; set_log(4'd0, 32'h40);
    fault_vec = '0;
    cyc("minor_c1", S_FREEZE, 1'b1, 4'd0);
    cyc("minor_c2", S_FREEZE, 1'b1, 4'd0);
    cyc("minor_c3", S_RECOVER, 1'b1, 4'd0);
    for (int i = 0; i < 8; i++) begin
      pc_current = 32'h44 + 32'(i * 4);
      cyc("minor_resume", S_RESUME, 1'b0, 4'd1);
    end
    cyc("minor_idle", S_IDLE, 1'b0, 4'd0);
  endtask

  task automatic test_critical_halt();
    do_reset();
    clear_halt = 1'b1;
    cyc("clr_in_idle", S_IDLE, 1'b0, 4'd0);
    clear_halt = 1'b0;
    pc_current = 32'h60;
    fault_vec = 4'b1000;
    cyc("crit_c0", S_IDLE, 1'b1, 4'd0);
    m_fcnt = 8'd1; set_log(4'd3, 32'h60);
    cyc("crit_halt1", S_HALT, 1'b1, 4'd0);
    cyc("crit_halt2", S_HALT, 1'b1, 4'd0);
    fault_vec = '0;
    cyc("crit_halt3", S_HALT, 1'b1, 4'd0);
    clear_halt = 1'b1;
    cyc("crit_clr", S_HALT, 1'b1, 4'd0);
    clear_halt = 1'b0; clr_log();
    cyc("crit_idle", S_IDLE, 1'b0, 4'd0);
    fault_vec = 4'b1000;
    cyc("crit2_c0", S_IDLE, 1'b1, 4'd0);
    m_fcnt = 8'd2; set_log(4'd3, 32'h60);
    clear_halt = 1'b1;
    cyc("clr_with_fault", S_HALT, 1'b1, 4'd0);
    clear_halt = 1'b0; clr_log();
    cyc("reeval_idle", S_IDLE, 1'b1, 4'd0);
    m_fcnt = 8'd3; set_log(4'd3, 32'h60);
    fault_vec = '0;
    cyc("reeval_halt", S_HALT, 1'b1, 4'd0);
    clear_halt = 1'b1;
    cyc("reeval_clr", S_HALT, 1'b1, 4'd0);
    clear_halt = 1'b0; clr_log();
    cyc("reeval_done", S_IDLE, 1'b0, 4'd0);
  endtask

  task automatic test_retry_exhaust();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pc_current = 32'h200 + 32'(k * 4);
      fault_vec = 4'b0010;
      cyc("exh_fault", (k == 0) ? S_IDLE : S_RESUME, 1'b1, 4'(k));
      m_fcnt = m_fcnt + 8'd1; set_log(4'd1, pc_current);
      fault_vec = '0;
      if (k < 3) begin
        cyc("exh_frz", S_FREEZE, 1'b1, 4'(k));
        cyc("exh_frz", S_FREEZE, 1'b1, 4'(k));
        cyc("exh_rec", S_RECOVER, 1'b1, 4'(k));
        cyc("exh_res", S_RESUME, 1'b0, 4'(k + 1));
      end
    end
    cyc("exh_halt", S_HALT, 1'b1, 4'd3);
    clear_halt = 1'b1;
    cyc("exh_clr", S_HALT, 1'b1, 4'd3);
    clear_halt = 1'b0; clr_log();
    cyc("exh_idle", S_IDLE, 1'b0, 4'd0);
  endtask

  task automatic test_crit_in_freeze();
    do_reset();
    fault_vec = 4'b0001;
    cyc("cf_c0", S_IDLE, 1'b1, 4'd0);
    m_fcnt = 8'd1; set_log(4'd0, pc_current);
    fault_vec = 4'b1000;
    cyc("cf_frz", S_FREEZE, 1'b1, 4'd0);
    m_fcnt = 8'd2;
    fault_vec = '0;
    cyc("cf_halt", S_HALT, 1'b1, 4'd0);
    cyc("cf_halt2", S_HALT, 1'b1, 4'd0);
  endtask

  task automatic test_fault_log();
    do_reset();
    pc_current = 32'h2C;
    fault_vec = 4'b0110;
    cyc("log_c0", S_IDLE, 1'b1, 4'd0);
    m_fcnt = 8'd1; set_log(4'd1, 32'h2C);
    fault_vec = '0;
    cyc("log_frz", S_FREEZE, 1'b1, 4'd0);
    cyc("log_frz", S_FREEZE, 1'b1, 4'd0);
    cyc("log_rec", S_RECOVER, 1'b1, 4'd0);
    cyc("log_res", S_RESUME, 1'b0, 4'd1);
    pc_current = 32'h80;
    fault_vec = 4'b0100;
    cyc("log_second", S_RESUME, 1'b1, 4'd1);
    m_fcnt = 8'd2; set_log(4'd2, 32'h80);
    fault_vec = '0;
    cyc("log_frz2", S_FREEZE, 1'b1, 4'd1);
    cyc("log_frz2", S_FREEZE, 1'b1, 4'd1);
    cyc("log_rec2", S_RECOVER, 1'b1, 4'd1);
    for (int i = 0; i < 8; i++) cyc("log_res2", S_RESUME, 1'b0, 4'd2);
    cyc("log_idle", S_IDLE, 1'b0, 4'd0);
  endtask

  task automatic test_fault_en_off();
    do_reset();
    fault_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      fault_vec = 4'($urandom);
      pc_current = $urandom;
      cyc("en_off", S_IDLE, 1'b0, 4'd0);
    end
    fault_en = 1'b1;
    fault_vec = 4'b0001;
    cyc("en_mid_c0", S_IDLE, 1'b1, 4'd0);
    m_fcnt = 8'd1; set_log(4'd0, pc_current);
    fault_en = 1'b0;
    fault_vec = 4'b1000;
    cyc("en_mid_frz", S_FREEZE, 1'b1, 4'd0);
    cyc("en_mid_frz", S_FREEZE, 1'b1, 4'd0);
    cyc("en_mid_rec", S_RECOVER, 1'b1, 4'd0);
    for (int i = 0; i < 8; i++) begin
      fault_vec = 4'($urandom);
      cyc("en_mid_res", S_RESUME, 1'b0, 4'd1);
    end
    cyc("en_mid_idle", S_IDLE, 1'b0, 4'd0);
    fault_en = 1'b1;
    fault_vec = '0;
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    fault_vec = 4'b0001;
    cyc("rm_c0", S_IDLE, 1'b1, 4'd0);
    m_fcnt = 8'd1; set_log(4'd0, pc_current);
    fault_vec = '0;
    cyc("rm_frz", S_FREEZE, 1'b1, 4'd0);
    cyc("rm_frz", S_FREEZE, 1'b1, 4'd0);
    cyc("rm_rec", S_RECOVER, 1'b1, 4'd0);
    fault_vec = 4'b0001;
    cyc("rm_res_fault", S_RESUME, 1'b1, 4'd1);
    m_fcnt = 8'd2;
    fault_vec = '0;
    cyc("rm_frz2", S_FREEZE, 1'b1, 4'd1);
    // Now inside the second FREEZE cycle; assert reset between edges.
    #2;
    checks += 2;
    if (retry_cnt !== 4'd1) begin errors++; $display("FAIL rm_pre retry_cnt: got %0d want 1", retry_cnt); end
    if (fault_count !== 8'd2) begin errors++; $display("FAIL rm_pre fault_count: got %0d want 2", fault_count); end
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (fsm_state !== S_IDLE) begin errors++; $display("FAIL rm state: got %0d want 0", fsm_state); end
    if (retry_cnt !== 4'd0) begin errors++; $display("FAIL rm retry_cnt: got %0d want 0", retry_cnt); end
    if (fault_count !== 8'd0) begin errors++; $display("FAIL rm fault_count: got %0d want 0", fault_count); end
    if ({pc_write_out, reg_write_out, mem_write_out} !== {pc_write_normal, reg_write_normal, mem_write_normal}) begin
      errors++; $display("FAIL rm writes: got %b want %b", {pc_write_out, reg_write_out, mem_write_out},
                         {pc_write_normal, reg_write_normal, mem_write_normal});
    end
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    m_fcnt = '0; clr_log();
    cyc("rm_after", S_IDLE, 1'b0, 4'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_minor_retry();
    test_critical_halt();
    test_retry_exhaust();
    test_crit_in_freeze();
    test_fault_log();
    test_fault_en_off();
    test_reset_mid_freeze();
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fault_recovery_manager.md
# fault_recovery_manager

Parametrised successor to the CPU's single-shot fault recovery path. Accepts `NUM_SRC` fault sources, each classified as minor or critical by a compile-time mask, and gates PC/register/memory writes. Runs a bounded retry loop: freeze, rewind PC, insert a NOP, resume under a clean-run watch window. Escalates to a latched HALT on a critical fault or when retries are exhausted. Sits between the control unit/hazard logic and the PC, register file and data-memory write enables.

## Interface
Parameters:
- `NUM_SRC`, 4: number of fault source lines (1..16)
- `CRIT_MASK`, 4'b1000: bit i = 1 marks source i critical; width `NUM_SRC`
- `XLEN`, 32: PC width
- `MAX_RETRY`, 3: minor-fault retries allowed before escalation (1..15)
- `FREEZE_CYCLES`, 2: cycles spent in FREEZE (>= 1)
- `CLEAN_WINDOW`, 8: fault-free cycles in RESUME required to clear the retry count (>= 1)
- `COUNT_W`, 8: width of the saturating fault counter

Ports:
- `clk`, in, 1: the single clock
- `reset_n`, in, 1: asynchronous reset, active-low
- `fault_en`, in, 1: global enable; 0 forces pass-through and ignores all faults
- `fault_vec`, in, `NUM_SRC`: level fault indications, sampled each cycle
- `clear_halt`, in, 1: single-cycle pulse that releases HALT
- `pc_write_normal`, `reg_write_normal`, `mem_write_normal`, in, 1 each: ungated enables
- `pc_current`, `pc_saved`, in, `XLEN` each: current PC and last committed good PC
- `pc_write_out`, `reg_write_out`, `mem_write_out`, out, 1 each: gated enables
- `pc_next`, out, `XLEN`: PC override value
- `pc_sel`, out, 1: 1 means the PC takes `pc_next`
- `insert_nop`, `retry_en`, out, 1 each: recovery strobes
- `halted`, out, 1: in HALT
- `retry_cnt`, out, 4: retries consumed in the current episode
- `fault_count`, out, `COUNT_W`: total accepted fault events, saturating
- `fsm_state`, out, 3: encoded state
- `log_valid`, out, 1: first-fault log holds an entry
- `log_src`, out, 4: first-fault source index
- `log_pc`, out, `XLEN`: first-fault PC

## Operation
- **States:** IDLE, FREEZE, RECOVER, RESUME, HALT. Encodings 0..4.
- **Fault detect:** `f = fault_en & |fault_vec`. `crit = fault_en & |(fault_vec & CRIT_MASK)`. The source is the lowest set index.
- **Safe mode:** `safe = (state in FREEZE/RECOVER/HALT) | (f & state in IDLE/RESUME)`. All three `*_write_out` are 0 when safe, otherwise they equal the normal inputs. This term is combinational, so the faulting cycle's own writes are suppressed.
- **IDLE / RESUME on `f`:**
  - If `crit`, or `retry_cnt == MAX_RETRY`, go to HALT.
  - Otherwise go to FREEZE and load the freeze counter with `FREEZE_CYCLES-1`.
- **FREEZE:** decrements the counter; at 0, goes to RECOVER. Minor faults are ignored here.
- **RECOVER:** lasts exactly one cycle.
  - `pc_sel=1`, `pc_next=pc_saved`, `insert_nop=1`, `retry_en=1`.
  - `retry_cnt` increments.
  - Next state is RESUME, with the window counter loaded to `CLEAN_WINDOW-1`.
- **RESUME:** normal writes. If the window reaches 0 with no fault, `retry_cnt` clears and the FSM goes to IDLE. A fault in RESUME keeps `retry_cnt`.
- **Critical fault in FREEZE or RECOVER:** goes to HALT next cycle. This takes priority over all other transitions.
- **HALT:** `halted=1`, writes gated. `clear_halt` leads to IDLE and clears `retry_cnt`. The fault log is also cleared.
- **`fault_count`:** increments on every cycle a transition to FREEZE or HALT is taken, and saturates at all-ones.
- **Pass-through defaults:** outside RECOVER, `pc_next=pc_current`, `pc_sel=0`, `insert_nop=0`, `retry_en=0`.
- **`fault_en=0` mid-episode:** the FSM finishes its current sequence without accepting new faults. HALT is still exited only by `clear_halt`.

## Timing
- **Reset values:** state IDLE; `retry_cnt` 0; `fault_count` 0; `halted` 0; `pc_sel`, `insert_nop`, `retry_en` 0; `log_*` 0. Write outputs follow the normal inputs, since not safe.
- **Latency (cycle 0 = fault cycle in IDLE):**
  - FREEZE occupies cycles 1..`FREEZE_CYCLES`.
  - RECOVER is cycle `FREEZE_CYCLES+1`.
  - RESUME starts at cycle `FREEZE_CYCLES+2`.
- **HALT entry:** `halted` rises the cycle after the fault.
- **Recovery strobes:** registered from state, glitch-free, high for exactly one cycle per retry.
- **`clear_halt` outside HALT:** ignored.
- **`clear_halt` with a simultaneous fault in HALT:** exits to IDLE. The fault is re-evaluated next cycle.
- **Reset mid-operation:** asynchronous return to IDLE with all counters cleared.

## Configuration
- Macro `FRM_FAULT_LOG_EN`.
- **Defined:** on the first accepted fault while `log_valid=0`, capture `log_src` and `log_pc=pc_current` and set `log_valid`. The log is sticky until `clear_halt` or reset.
- **Undefined:** the log registers are not built. `log_valid`, `log_src` and `log_pc` are tied to 0.

## Structure
- **Package `frm_pkg`:** `frm_state_e` enum (IDLE=0..HALT=4) and the fault-encoding widths.
- **Sub-module `frm_priority_enc`:** `NUM_SRC`-input lowest-index encoder producing index and any-valid, used for the log source and any-fault detection.
- **Top level:** FSM, counters and gating.

## Test plan
- Source 0 pulses 1 cycle in IDLE, with `pc_saved=0x100` and `FREEZE_CYCLES=2` -> writes gated in cycles 0..3; RECOVER in cycle 3 with `pc_next=0x100`, `insert_nop=1`, `retry_en=1`; `retry_cnt=1`; IDLE after 8 clean cycles with `retry_cnt=0`.
- Source 3 (critical) asserted -> `halted=1` next cycle and writes stay gated; `clear_halt` -> IDLE; `fault_count=1`.
- Four minor faults each landing inside RESUME, with `MAX_RETRY=3` -> the fourth goes to HALT with `retry_cnt=3`.
- Critical fault during FREEZE -> HALT next cycle; no RECOVER strobe.
- Sources 1 and 2 set together with `FRM_FAULT_LOG_EN` defined and `pc_current=0x2C` -> `log_src=1`, `log_pc=0x2C`; a later fault does not overwrite the log. Same stimulus with the macro undefined -> all `log_*` read 0.
- `fault_en=0` with faults toggling -> outputs always equal the normal inputs; `reset_n` asserted during FREEZE -> IDLE immediately with counters 0.
